// File: rtl/tds_channel_buffer_if.sv
// Handshake/data bundle for tds_channel_buffer: the frame producer and the
// reader drive through the master modport, the buffer sits on the slave modport.
interface tds_channel_buffer_if #(
    parameter int DATA_W     = 120,
    parameter int DEPTH_LOG2 = 9
);
    logic [DATA_W-1:0]   frame_in;
    logic                frame_valid;
    logic                tds_mode;
    logic                enable;
    logic                channel_fifo_s_reset;
    logic                data_tran_stop;
    logic                channel_data_read;
    logic [DATA_W-1:0]   channel_data;
    logic [DEPTH_LOG2:0] channel_data_counter;
    logic                channel_fifo_empty;
    logic [15:0]         drop_count;

    modport master (
        output frame_in, frame_valid, tds_mode, enable,
               channel_fifo_s_reset, data_tran_stop, channel_data_read,
        input  channel_data, channel_data_counter, channel_fifo_empty, drop_count
    );

    modport slave (
        input  frame_in, frame_valid, tds_mode, enable,
               channel_fifo_s_reset, data_tran_stop, channel_data_read,
        output channel_data, channel_data_counter, channel_fifo_empty, drop_count
    );
endinterface

// File: rtl/tds_channel_buffer.sv
// Per-channel TDS frame FIFO (first-word-fall-through) with idle-frame filtering.
// Optional drop counter built only when TDS_BUF_DROP_CNT_EN is defined.
module tds_channel_buffer #(
    parameter int DEPTH_LOG2 = 9,
    parameter int DATA_W     = 120
) (
    input  logic                 clk,
    input  logic                 reset,
    tds_channel_buffer_if.slave  bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] count_q,  count_d;

    logic payload_nz;
    logic live;
    logic full;
    logic empty;
    logic wr_en;
    logic pop;

    // Extra MSB on each pointer disambiguates full from empty.
    assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                   (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    always_comb begin
        payload_nz = bus.tds_mode ? |bus.frame_in[111:0] : |bus.frame_in[103:0];
        live       = bus.frame_valid & bus.enable & payload_nz;
        pop        = bus.channel_data_read & ~empty & ~bus.channel_fifo_s_reset;
        // A full FIFO still accepts a frame when the head leaves on the same edge.
        wr_en      = live & ~bus.data_tran_stop & (~full | bus.channel_data_read) &
                     ~bus.channel_fifo_s_reset;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.channel_fifo_s_reset) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
            case ({wr_en, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left unreset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[PW-2:0]] <= bus.frame_in;
    end

    assign bus.channel_data         = empty ? '0 : mem_q[rd_ptr_q[PW-2:0]];
    assign bus.channel_data_counter = count_q;
    assign bus.channel_fifo_empty   = empty;

`ifdef TDS_BUF_DROP_CNT_EN
    logic        drop;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    assign drop = live & ~wr_en & ~bus.channel_fifo_s_reset;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (bus.channel_fifo_s_reset)
            drop_cnt_d = '0;
        else if (drop && drop_cnt_q != 16'hFFFF)
            drop_cnt_d = drop_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) drop_cnt_q <= '0;
        else       drop_cnt_q <= drop_cnt_d;
    end

    assign bus.drop_count = drop_cnt_q;
`else
    assign bus.drop_count = 16'h0000;
`endif

endmodule

// File: tb/tb_tds_channel_buffer.sv
// Directed bench for tds_channel_buffer; drop expectations follow TDS_BUF_DROP_CNT_EN.
`timescale 1ns/1ps
module tb_tds_channel_buffer;
    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #3 clk = ~clk;

    tds_channel_buffer_if #(.DATA_W(120), .DEPTH_LOG2(9)) bus ();

    tds_channel_buffer #(.DEPTH_LOG2(9), .DATA_W(120)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [119:0] mk(input int v);
        logic [119:0] f;
        f = '0;
        f[31:0] = v;
        return f;
    endfunction

    // Expected drop_count value for a given number of dropped frames.
    function automatic logic [15:0] ed(input int n);
`ifdef TDS_BUF_DROP_CNT_EN
        return 16'(n);
`else
        return 16'(n) & 16'h0000;
`endif
    endfunction

    logic [119:0] f110;

    initial begin
        reset = 1'b1;
        bus.frame_in = '0;
        bus.frame_valid = 0;
        bus.tds_mode = 0;
        bus.enable = 1;
        bus.channel_fifo_s_reset = 0;
        bus.data_tran_stop = 0;
        bus.channel_data_read = 0;
        #1;
        chk("rst_empty", bus.channel_fifo_empty, 1);
        chk("rst_cnt",   bus.channel_data_counter, 0);
        chk("rst_drop",  bus.drop_count, 0);
        chk("rst_data",  bus.channel_data, 0);
        tick(); tick();
        reset = 1'b0;

        // pad-mode ordering
        bus.frame_valid = 1; bus.frame_in = mk(1); tick();
        chk("w1_empty", bus.channel_fifo_empty, 0);
        chk("w1_data",  bus.channel_data, mk(1));
        bus.frame_in = mk(2); tick();
        bus.frame_in = mk(3); tick();
        bus.frame_valid = 0;
        chk("w3_cnt",  bus.channel_data_counter, 3);
        chk("w3_head", bus.channel_data, mk(1));
        bus.channel_data_read = 1; tick();
        chk("p1_cnt",  bus.channel_data_counter, 2);
        chk("p1_data", bus.channel_data, mk(2));
        tick();
        chk("p2_cnt",  bus.channel_data_counter, 1);
        chk("p2_data", bus.channel_data, mk(3));
        tick();
        chk("p3_cnt",   bus.channel_data_counter, 0);
        chk("p3_empty", bus.channel_fifo_empty, 1);
        bus.channel_data_read = 0;

        // idle filter and mode switch
        f110 = '0; f110[110] = 1'b1;
        bus.frame_valid = 1; bus.frame_in = f110; bus.tds_mode = 0; tick();
        chk("idle_pad_cnt", bus.channel_data_counter, 0);
        bus.tds_mode = 1; tick();
        bus.frame_valid = 0; bus.tds_mode = 0;
        chk("idle_strip_cnt",  bus.channel_data_counter, 1);
        chk("idle_strip_data", bus.channel_data, f110);
        tick();
        chk("mode_chg_data", bus.channel_data, f110);
        chk("idle_drop",     bus.drop_count, 0);
        bus.channel_data_read = 1; tick();
        bus.channel_data_read = 0;
        chk("idle_pop_empty", bus.channel_fifo_empty, 1);

        // disabled channel
        bus.enable = 0; bus.frame_valid = 1; bus.frame_in = mk(7); tick();
        bus.enable = 1; bus.frame_valid = 0;
        chk("dis_cnt",  bus.channel_data_counter, 0);
        chk("dis_drop", bus.drop_count, 0);

        // stop drops, then empty read
        bus.data_tran_stop = 1; bus.frame_valid = 1;
        for (int k = 0; k < 5; k++) begin
            bus.frame_in = mk(k + 1); tick();
        end
        bus.data_tran_stop = 0; bus.frame_valid = 0;
        chk("stop_drop", bus.drop_count, ed(5));
        chk("stop_cnt",  bus.channel_data_counter, 0);
        bus.channel_data_read = 1; tick();
        bus.channel_data_read = 0;
        chk("erd_cnt",   bus.channel_data_counter, 0);
        chk("erd_empty", bus.channel_fifo_empty, 1);
        chk("erd_drop",  bus.drop_count, ed(5));

        bus.channel_fifo_s_reset = 1; tick();
        bus.channel_fifo_s_reset = 0;
        chk("sr0_drop", bus.drop_count, 0);

        // fill to capacity
        bus.frame_valid = 1;
        for (int i = 0; i < 512; i++) begin
            bus.frame_in = mk(i + 1); tick();
        end
        chk("full_cnt", bus.channel_data_counter, 512);
        bus.frame_in = mk(600); tick();
        chk("ovf_cnt",  bus.channel_data_counter, 512);
        chk("ovf_drop", bus.drop_count, ed(1));
        chk("ovf_head", bus.channel_data, mk(1));
        bus.frame_in = mk(700); bus.channel_data_read = 1; tick();
        bus.channel_data_read = 0; bus.frame_valid = 0;
        chk("frw_cnt",  bus.channel_data_counter, 512);
        chk("frw_head", bus.channel_data, mk(2));
        chk("frw_drop", bus.drop_count, ed(1));

        // s_reset priority over read and write
        bus.channel_fifo_s_reset = 1; tick();
        bus.channel_fifo_s_reset = 0;
        bus.frame_valid = 1;
        for (int i = 0; i < 10; i++) begin
            bus.frame_in = mk(i + 100); tick();
        end
        bus.data_tran_stop = 1;
        for (int i = 0; i < 3; i++) begin
            bus.frame_in = mk(i + 200); tick();
        end
        bus.data_tran_stop = 0;
        chk("pre_sr_cnt",  bus.channel_data_counter, 10);
        chk("pre_sr_drop", bus.drop_count, ed(3));
        bus.channel_fifo_s_reset = 1; bus.channel_data_read = 1; bus.frame_in = mk(9); tick();
        bus.channel_fifo_s_reset = 0; bus.channel_data_read = 0; bus.frame_valid = 0;
        chk("sr_cnt",   bus.channel_data_counter, 0);
        chk("sr_empty", bus.channel_fifo_empty, 1);
        chk("sr_drop",  bus.drop_count, 0);
        tick();
        chk("sr_hold_empty", bus.channel_fifo_empty, 1);

        // async reset mid-burst
        bus.data_tran_stop = 1; bus.frame_valid = 1; bus.frame_in = mk(11); tick();
        bus.data_tran_stop = 0;
        for (int i = 0; i < 3; i++) begin
            bus.frame_in = mk(i + 20); tick();
        end
        chk("burst_cnt",  bus.channel_data_counter, 3);
        chk("burst_drop", bus.drop_count, ed(1));
        reset = 1'b1;
        #1;
        chk("ar_empty", bus.channel_fifo_empty, 1);
        chk("ar_cnt",   bus.channel_data_counter, 0);
        chk("ar_drop",  bus.drop_count, 0);
        chk("ar_data",  bus.channel_data, 0);
        tick();
        reset = 1'b0;
        bus.frame_in = mk(50); tick();
        bus.frame_valid = 0;
        chk("post_ar_cnt",  bus.channel_data_counter, 1);
        chk("post_ar_data", bus.channel_data, mk(50));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
